// File: rtl/imm_ext_if.sv
// Request/result bundle for the immediate-extension pipeline.
//   master : drives in_valid, ext_op, imm16, pc_plus4, stall, flush;
//            receives out_valid, imm_out, op_err
//   slave  : the pipeline side of the same signals
interface imm_ext_if #(
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic [2:0]       ext_op;
  logic [15:0]      imm16;
  logic [OUT_W-1:0] pc_plus4;
  logic             stall;
  logic             flush;
  logic             out_valid;
  logic [OUT_W-1:0] imm_out;
  logic             op_err;

  modport master (
    output in_valid, ext_op, imm16, pc_plus4, stall, flush,
    input  out_valid, imm_out, op_err
  );

  modport slave (
    input  in_valid, ext_op, imm16, pc_plus4, stall, flush,
    output out_valid, imm_out, op_err
  );
endinterface

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate generator for the decode/execute boundary.
// Extends imm16 to OUT_W bits (zero, sign, high, sign<<2, branch target)
// and carries the result through STAGES registers with stall/flush.
// Ports:
//   clk  : core clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : imm_ext_if slave (request in, result/op_err out)
module imm_ext_pipe #(
  parameter int OUT_W  = 32,
  parameter int STAGES = 1
) (
  input  logic      clk,
  input  logic      rst,
  imm_ext_if.slave  bus
);

  localparam logic [2:0] OP_ZERO     = 3'b000;
  localparam logic [2:0] OP_SIGN     = 3'b001;
  localparam logic [2:0] OP_HIGH     = 3'b010;
  localparam logic [2:0] OP_SIGN_SH2 = 3'b011;
  localparam logic [2:0] OP_BRANCH   = 3'b100;

  logic [OUT_W-1:0] w_zext;
  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_sh2;
  logic [OUT_W-1:0] w_result;
  logic             w_illegal;
  logic             w_accept;

  logic [STAGES-1:0] r_valid;
  logic [OUT_W-1:0]  r_data [STAGES];
  logic              r_op_err;

  assign w_zext = {{(OUT_W-16){1'b0}}, bus.imm16};
  assign w_sext = {{(OUT_W-16){bus.imm16[15]}}, bus.imm16};
  assign w_sh2  = {w_sext[OUT_W-3:0], 2'b00};

  always_comb begin
    w_result  = w_zext;
    w_illegal = 1'b0;
    case (bus.ext_op)
      OP_ZERO:     w_result = w_zext;
      OP_SIGN:     w_result = w_sext;
      OP_HIGH:     w_result = {w_sext[OUT_W-17:0], 16'h0000};
      OP_SIGN_SH2: w_result = w_sh2;
      OP_BRANCH:   w_result = bus.pc_plus4 + w_sh2;
      default: begin
        // illegal ops still produce the zero-extended value
        w_result  = w_zext;
        w_illegal = 1'b1;
      end
    endcase
  end

  assign w_accept = bus.in_valid & ~bus.stall & ~bus.flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= '0;
      r_op_err <= 1'b0;
      for (int k = 0; k < STAGES; k++) r_data[k] <= '0;
    end else if (bus.flush) begin
      // flush wins over stall; op_err is deliberately kept
      r_valid <= '0;
      for (int k = 0; k < STAGES; k++) r_data[k] <= '0;
    end else if (!bus.stall) begin
      r_valid[0] <= bus.in_valid;
      r_data[0]  <= bus.in_valid ? w_result : '0;
      for (int k = 1; k < STAGES; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_data[k]  <= r_data[k-1];
      end
      if (w_accept && w_illegal) r_op_err <= 1'b1;
    end
  end

  assign bus.out_valid = r_valid[STAGES-1];
  assign bus.imm_out   = r_data[STAGES-1];
  assign bus.op_err    = r_op_err;

endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Parametrised, pipelined immediate-generation unit for the pipeline CPU decode/execute boundary.
- Extends a 16-bit instruction immediate to OUT_W bits under one of five modes, including shifted branch offset and full branch-target add.
- Output is registered through STAGES pipeline registers that honour the pipeline's stall and flush controls.

Parameters:
- OUT_W, 32, output width in bits; legal range 32..64.
- STAGES, 1, number of register stages from input to output; legal range 1..4.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  the current ext_op/imm16/pc_plus4 form a valid request.
- ext_op  input  3  mode: 000 ZERO, 001 SIGN, 010 HIGH, 011 SIGN_SH2, 100 BRANCH; 101..111 are illegal.
- imm16  input  16  raw immediate.
- pc_plus4  input  OUT_W  PC+4 of the instruction; used only in BRANCH mode.
- stall  input  1  hold every stage; ignore inputs this cycle.
- flush  input  1  invalidate every stage.
- out_valid  output  1  imm_out holds a valid result.
- imm_out  output  OUT_W  extended result.
- op_err  output  1  sticky flag; set by any accepted request with an illegal ext_op.

Behaviour:
- Reset: when rst=1 at a rising edge, all stage valids, all stage data and op_err clear to 0. The outputs are then out_valid=0, imm_out=0, op_err=0. rst overrides stall and flush, including mid-operation.
- Mode arithmetic, combinational ahead of stage 1. S is the sign-extension of imm16 to OUT_W.
  - ZERO: zero-extension of imm16.
  - SIGN: S.
  - HIGH: {S[OUT_W-17:0], 16'b0}, which is imm16<<16 sign-extended to OUT_W.
  - SIGN_SH2: S<<2, truncated to OUT_W.
  - BRANCH: pc_plus4 + (S<<2), modulo 2^OUT_W; wrap-around is silent.
  - Illegal op: result equals the ZERO mode result.
- Stage-1 load, when rst=0, stall=0 and flush=0:
  - valid1 <= in_valid.
  - data1 <= the result if in_valid=1, else 0.
- Stage k>1 load, under the same conditions: valid_k <= valid_{k-1} and data_k <= data_{k-1}.
- out_valid = valid_STAGES and imm_out = data_STAGES.
- Latency: exactly STAGES unstalled cycles from acceptance to out_valid. Throughput is one request per cycle, with no bubbles inserted.
- Stall (stall=1, flush=0): every stage keeps its valid and data. Inputs are not sampled, and op_err is not updated.
  - Upstream must hold the request across the stall.
  - Outputs are stable for the entire stall.
- Flush (flush=1): all valids and data clear to 0 at the edge. The input in that cycle is discarded and does not affect op_err.
  - Flush takes priority over stall.
  - op_err is not cleared by flush.
- op_err: set to 1 at the edge when a request is accepted (rst=0, stall=0, flush=0, in_valid=1) with ext_op in 101..111. Only rst clears it.
- An invariant holds after reset: out_valid=0 implies imm_out=0.

Test Plan:
- SIGN mode, STAGES=1: imm16=16'h8001, in_valid=1 -> next cycle out_valid=1, imm_out=32'hFFFF8001. With OUT_W=64 -> 64'hFFFFFFFFFFFF8001.
- Mode sweep with imm16=16'h1234, back-to-back over ZERO, HIGH, SIGN_SH2 -> on consecutive cycles imm_out=32'h00001234, 32'h12340000, 32'h000048D0; out_valid stays high.
- BRANCH mode, imm16=16'hFFFF, pc_plus4=32'h00400010 -> imm_out=32'h0040000C. With imm16=16'h0001 and pc_plus4=32'hFFFFFFFC -> imm_out=32'h00000000 (wrap).
- STAGES=3: issue A, then hold stall=1 for 2 cycles, then release -> A appears with out_valid=1 exactly 3 unstalled cycles after acceptance; outputs are frozen while stalled.
- Flush mid-pipe, STAGES=3: two requests in flight, assert flush together with stall -> next cycle out_valid=0, imm_out=0; no result appears on the following 3 cycles.
- Illegal op: ext_op=3'b111, imm16=16'hABCD, accepted -> imm_out=32'h0000ABCD and op_err=1. op_err stays 1 through a flush and new legal ops, and clears only when rst=1.
